multicycle_addsub: RTL and testbench

MULTICYCLE_ADDSUB -- requirements
Module: multicycle_addsub

---
 rtl/addsub_pkg.sv | 13 +
 rtl/adder_chunk.sv | 28 ++
 rtl/multicycle_addsub.sv | 155 +++++++++++++++
 tb/tb_multicycle_addsub.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared FSM state encoding and default geometry for the chunked adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

endpackage

// File: rtl/adder_chunk.sv
// CHUNK-bit combinational ripple adder; also exposes the carry into its MSB
// so the caller can derive signed overflow on the top chunk.
module adder_chunk
  import addsub_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
    assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = c[CHUNK];
  assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/multicycle_addsub.sv
// Multicycle add/subtract: one CHUNK-bit slice per cycle through a single adder_chunk.
// Optional saturation on signed overflow is compiled in with `define ADDSUB_SAT_EN.
module multicycle_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             over,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if ((WIDTH % CHUNK) != 0 || WIDTH < 2) begin : g_bad_geometry
    $error("multicycle_addsub: WIDTH (%0d) must be a multiple of CHUNK (%0d) and >= 2",
           WIDTH, CHUNK);
  end

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             sub_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_out_reg;
  logic             over_reg;
  logic             zero_reg;

  // Operand slices, indexed by the chunk counter.
  logic [CHUNK-1:0] a_chunk [NCHUNK];
  logic [CHUNK-1:0] b_chunk [NCHUNK];

  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
    assign a_chunk[gi] = a_reg[gi*CHUNK +: CHUNK];
    assign b_chunk[gi] = b_reg[gi*CHUNK +: CHUNK];
  end

  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;
  logic             chunk_cmsb;

  adder_chunk #(.CHUNK(CHUNK)) u_adder (
    .a    (a_chunk[cnt_reg]),
    .b    (b_chunk[cnt_reg]),
    .cin  (carry_reg),
    .sum  (chunk_sum),
    .cout (chunk_cout),
    .cmsb (chunk_cmsb)
  );

  logic             last_chunk;
  logic             ovf;
  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] final_sum;

  assign last_chunk = (cnt_reg == LAST);

  // On the last chunk the top slice is still in flight, so splice it in here.
  always_comb begin
    raw_sum = acc_reg;
    raw_sum[WIDTH-1 -: CHUNK] = chunk_sum;
    ovf = chunk_cmsb ^ chunk_cout;
    final_sum = raw_sum;
`ifdef ADDSUB_SAT_EN
    if (ovf) begin
      final_sum = a_reg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)   state_next = CALC;
      CALC:    if (last_chunk) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg         <= '0;
      b_reg         <= '0;
      sub_reg       <= 1'b0;
      carry_reg     <= 1'b0;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      sum_reg       <= '0;
      carry_out_reg <= 1'b0;
      over_reg      <= 1'b0;
      zero_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            carry_reg <= sub ? 1'b1 : cin;
            sub_reg   <= sub;
            cnt_reg   <= '0;
          end
        end
        CALC: begin
          acc_reg[int'(cnt_reg)*CHUNK +: CHUNK] <= chunk_sum;
          carry_reg <= chunk_cout;
          cnt_reg   <= cnt_reg + 1'b1;
          // Visible results change only when the whole operation is complete.
          if (last_chunk) begin
            sum_reg       <= final_sum;
            carry_out_reg <= chunk_cout & ~sub_reg;
            over_reg      <= ovf;
            zero_reg      <= (final_sum == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign sum       = sum_reg;
  assign carry     = carry_out_reg;
  assign over      = over_reg;
  assign zero      = zero_reg;

endmodule

// File: tb/tb_multicycle_addsub.sv
// Directed bench for multicycle_addsub (WIDTH=32, CHUNK=8); expected values are hand-computed.
module tb_multicycle_addsub;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             over;
  logic             zero;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .over      (over),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] oa, input logic [31:0] ob,
                          input logic ocin, input logic osub);
    @(negedge clk);
    check("start_in_ready", 32'(in_ready), 32'd1);
    a = oa; b = ob; cin = ocin; sub = osub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble operands after the accept edge; they must be ignored.
    a = ~oa; b = ~ob; cin = ~ocin; sub = ~osub;
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(NCHUNK));
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_idle_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] oa, input logic [31:0] ob,
                        input logic ocin, input logic osub, input logic [31:0] es,
                        input logic ec, input logic eo, input logic ez);
    start_op(oa, ob, ocin, osub);
    wait_done(tag);
    $display("[TB] op %s a=%h b=%h cin=%0d sub=%0d -> sum=%h c=%0d o=%0d z=%0d",
             tag, oa, ob, ocin, osub, sum, carry, over, zero);
    check({tag, "_sum"},   sum,          es);
    check({tag, "_carry"}, 32'(carry),   32'(ec));
    check({tag, "_over"},  32'(over),    32'(eo));
    check({tag, "_zero"},  32'(zero),    32'(ez));
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    release_result(tag);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum",       sum,            32'h0);
    check("rst_flags",     {29'd0, carry, over, zero}, 32'd0);
    rst_n = 1'b1;

    run_op("wrap_ffff", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
`ifdef ADDSUB_SAT_EN
    run_op("ovf_pos", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    run_op("ovf_sub", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_op("ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
`else
    run_op("ovf_pos", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_op("ovf_sub", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    run_op("ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
`endif
    run_op("sub_neg",   32'h5,         32'h7,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_op("add_cin",   32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 1'b0);
    run_op("chunk_cy",  32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    run_op("sub_eq",    32'h0000_1234, 32'h0000_1234, 1'b0, 1'b1, 32'h0,         1'b0, 1'b0, 1'b1);
    run_op("sub_nocin", 32'h0000_000A, 32'h0000_0003, 1'b0, 1'b1, 32'h7,         1'b0, 1'b0, 1'b0);

    // Back-pressure: hold DONE with stray in_valid pulses.
    start_op(32'h5, 32'h7, 1'b0, 1'b0);
    wait_done("hold");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 32'hDEAD_0000 + 32'(i); b = 32'h1; sub = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      $display("[TB] op hold cycle %0d sum=%h out_valid=%0d in_ready=%0d", i, sum, out_valid, in_ready);
      check("hold_sum",       sum,             32'hC);
      check("hold_out_valid", 32'(out_valid),  32'd1);
      check("hold_in_ready",  32'(in_ready),   32'd0);
    end
    release_result("hold");
    check("idle_keeps_sum", sum, 32'hC);
    run_op("after_hold", 32'h0000_0100, 32'h0000_0023, 1'b0, 1'b0, 32'h0000_0123, 1'b0, 1'b0, 1'b0);

    // Reset in the second CALC cycle discards the operation.
    start_op(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    $display("[TB] op midreset out_valid=%0d in_ready=%0d sum=%h", out_valid, in_ready, sum);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_sum",       sum,            32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < NCHUNK + 2; i++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      check("midrst_no_result", 32'(seen), 32'd0);
    end
    run_op("after_rst", 32'h0000_0064, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0063, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
